// File: rtl/seg7_pkg.sv
// Shared segment constants and nibble decode for the 7-segment driver.
// Patterns are active-high with bit 0 = segment a through bit 6 = segment g.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [7:0] AN_RESET = 8'h01;

  // Codes 10-15 show a dash instead of a letter when hex_mode is low.
  function automatic logic [6:0] seg7_decode_fn(input logic [3:0] value,
                                                input logic       hex_mode);
    logic [6:0] seg;
    case (value)
      4'd0:  seg = SEG_0;
      4'd1:  seg = SEG_1;
      4'd2:  seg = SEG_2;
      4'd3:  seg = SEG_3;
      4'd4:  seg = SEG_4;
      4'd5:  seg = SEG_5;
      4'd6:  seg = SEG_6;
      4'd7:  seg = SEG_7;
      4'd8:  seg = SEG_8;
      4'd9:  seg = SEG_9;
      4'd10: seg = hex_mode ? SEG_A : SEG_DASH;
      4'd11: seg = hex_mode ? SEG_B : SEG_DASH;
      4'd12: seg = hex_mode ? SEG_C : SEG_DASH;
      4'd13: seg = hex_mode ? SEG_D : SEG_DASH;
      4'd14: seg = hex_mode ? SEG_E : SEG_DASH;
      4'd15: seg = hex_mode ? SEG_F : SEG_DASH;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic [7:0] an_onehot_fn(input logic [2:0] sel);
    logic [7:0] an;
    case (sel)
      3'd0: an = 8'h01;
      3'd1: an = 8'h02;
      3'd2: an = 8'h04;
      3'd3: an = 8'h08;
      3'd4: an = 8'h10;
      3'd5: an = 8'h20;
      3'd6: an = 8'h40;
      3'd7: an = 8'h80;
      default: an = AN_RESET;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder, active-high pattern out.
module seg7_decode
  import seg7_pkg::*;
#(
  parameter bit HEX_MODE = 1'b1
) (
  input  logic [3:0] value,
  output logic [6:0] seg
);

  assign seg = seg7_decode_fn(value, HEX_MODE);

endmodule

// File: rtl/driver_7seg.sv
// Registered single-digit 7-segment driver: captures value/select/blank/dp on
// en and holds the decoded, polarity-adjusted segment and anode outputs.
module driver_7seg
  import seg7_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b0,
  parameter bit HEX_MODE       = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] b,
  input  logic [2:0] sel,
  input  logic       blank,
  input  logic       dp,
  output logic [6:0] d,
  output logic       dp_out,
  output logic [7:0] an
);

  localparam logic [6:0] SEG_MASK = {7{SEG_ACTIVE_LOW}};
  localparam logic [7:0] AN_MASK  = {8{AN_ACTIVE_LOW}};

  logic [6:0] seg_raw;
  logic [6:0] seg_gated;
  logic       dp_gated;

  seg7_decode #(
    .HEX_MODE(HEX_MODE)
  ) u_decode (
    .value(b),
    .seg  (seg_raw)
  );

  // Blanking darkens the digit but leaves its anode selected.
  assign seg_gated = blank ? SEG_BLANK : seg_raw;
  assign dp_gated  = dp & ~blank;

  always_ff @(posedge clk) begin
    if (rst) begin
      d      <= SEG_0 ^ SEG_MASK;
      dp_out <= SEG_ACTIVE_LOW;
      an     <= AN_RESET ^ AN_MASK;
    end else if (en) begin
      d      <= seg_gated ^ SEG_MASK;
      dp_out <= dp_gated ^ SEG_ACTIVE_LOW;
      an     <= an_onehot_fn(sel) ^ AN_MASK;
    end
  end

endmodule

// File: tb/tb_driver_7seg.sv
// Self-checking bench for driver_7seg: three parameterisations share stimulus
// and are compared against a value/select/blank/dp reference model.
module tb_driver_7seg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [3:0] b = 4'd0;
  logic [2:0] sel = 3'd0;
  logic       blank = 1'b0;
  logic       dp = 1'b0;

  logic [6:0] d_h, d_x, d_p;
  logic       dp_h, dp_x, dp_p;
  logic [7:0] an_h, an_x, an_p;

  int checks = 0;
  int errors = 0;

  logic [6:0] tab [16];
  int m_val, m_sel;
  logic m_blank, m_dp;

  always #5 clk = ~clk;

  driver_7seg #(.SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0), .HEX_MODE(1'b1)) u_hex (
    .clk(clk), .rst(rst), .en(en), .b(b), .sel(sel), .blank(blank), .dp(dp),
    .d(d_h), .dp_out(dp_h), .an(an_h));

  driver_7seg #(.SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0), .HEX_MODE(1'b0)) u_dash (
    .clk(clk), .rst(rst), .en(en), .b(b), .sel(sel), .blank(blank), .dp(dp),
    .d(d_x), .dp_out(dp_x), .an(an_x));

  driver_7seg #(.SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .HEX_MODE(1'b1)) u_pol (
    .clk(clk), .rst(rst), .en(en), .b(b), .sel(sel), .blank(blank), .dp(dp),
    .d(d_p), .dp_out(dp_p), .an(an_p));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input bit hex_mode);
    if (m_blank) return 7'h00;
    if (m_val >= 10 && !hex_mode) return 7'h40;
    return tab[m_val];
  endfunction

  task automatic check_all();
    logic [7:0] an_e;
    an_e = 8'd1 << m_sel;
    chk("hex_d",   {25'd0, d_h},  {25'd0, exp_seg(1'b1)});
    chk("hex_dp",  {31'd0, dp_h}, {31'd0, m_dp & ~m_blank});
    chk("hex_an",  {24'd0, an_h}, {24'd0, an_e});
    chk("dash_d",  {25'd0, d_x},  {25'd0, exp_seg(1'b0)});
    chk("dash_dp", {31'd0, dp_x}, {31'd0, m_dp & ~m_blank});
    chk("dash_an", {24'd0, an_x}, {24'd0, an_e});
    chk("pol_d",   {25'd0, d_p},  {25'd0, ~exp_seg(1'b1)});
    chk("pol_dp",  {31'd0, dp_p}, {31'd0, ~(m_dp & ~m_blank)});
    chk("pol_an",  {24'd0, an_p}, {24'd0, ~an_e});
  endtask

  // Apply inputs, clock one edge, update the model, check one tick later.
  task automatic step(input logic r, input logic e, input int v, input int s,
                      input logic bl, input logic p);
    rst = r; en = e; b = v[3:0]; sel = s[2:0]; blank = bl; dp = p;
    @(posedge clk);
    if (r) begin
      m_val = 0; m_sel = 0; m_blank = 1'b0; m_dp = 1'b0;
    end else if (e) begin
      m_val = v & 15; m_sel = s & 7; m_blank = bl; m_dp = p;
    end
    #1;
    check_all();
  endtask

  initial begin
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    m_val = 0; m_sel = 0; m_blank = 1'b0; m_dp = 1'b0;
    @(negedge clk);

    // Reset wins over a simultaneous load of 9.
    step(1'b1, 1'b1, 9, 3, 1'b1, 1'b1);
    step(1'b1, 1'b1, 9, 3, 1'b1, 1'b1);
    chk("rst_d_const", {25'd0, d_h}, 32'h3F);
    chk("rst_an_const", {24'd0, an_h}, 32'h01);
    chk("rst_pol_d_const", {25'd0, d_p}, 32'h40);
    chk("rst_pol_an_const", {24'd0, an_p}, 32'hFE);

    for (int v = 0; v < 16; v++) step(1'b0, 1'b1, v, 0, 1'b0, 1'b0);

    // Hold: inputs wander with en low.
    step(1'b0, 1'b1, 5, 7, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, int'($urandom_range(15)), int'($urandom_range(7)),
           1'($urandom), 1'($urandom));
    chk("hold_d_const", {25'd0, d_h}, 32'h6D);
    chk("hold_an_const", {24'd0, an_h}, 32'h80);

    for (int s = 0; s < 8; s++)
      step(1'b0, 1'b1, int'($urandom_range(15)), s, 1'b0, 1'($urandom));

    step(1'b0, 1'b1, 8, 4, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8, 4, 1'b1, 1'b1);

    step(1'b0, 1'b1, 3, 1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1, 2, 1'b0, 1'b0);
    chk("pol_load_d_const", {25'd0, d_p}, 32'h79);
    chk("pol_load_an_const", {24'd0, an_p}, 32'hFB);

    for (int i = 0; i < 300; i++)
      step(($urandom_range(15) == 0), 1'($urandom), int'($urandom_range(15)),
           int'($urandom_range(7)), ($urandom_range(3) == 0), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
